nonce_reporter: RTL and testbench

NONCE_REPORTER -- requirements
Module: nonce_reporter

---
 rtl/nonce_reporter_pkg.sv | 20 ++
 rtl/nonce_reporter_uart_tx.sv | 66 ++++++
 rtl/nonce_reporter.sv | 151 +++++++++++++++
 tb/tb_nonce_reporter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nonce_reporter_pkg.sv
// Shared definitions for the nonce reporter: controller state encoding and
// framing constants used by the top level and the UART serializer.
package nonce_reporter_pkg;

    // Controller states; the encoding is visible on the dbg_state output.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam int BYTES_PER_NONCE = 4;
    localparam int FRAME_BITS      = 10;

    // Terminal values for the byte index and the in-frame bit index.
    localparam logic [1:0] LAST_BYTE_IDX = 2'(BYTES_PER_NONCE - 1);
    localparam logic [3:0] LAST_BIT_IDX  = 4'(FRAME_BITS - 1);

endpackage

// File: rtl/nonce_reporter_uart_tx.sv
// 8N1 UART serializer: start bit, eight data bits LSB first, stop bit,
// each bit held for exactly CLK_DIV clocks.
//
// Handshake: start is sampled only while ready is high (no frame in flight);
// the byte on data is captured at that edge and tx drops to the start bit.
// done is a single-cycle combinational pulse during the last clock of the
// stop bit; ready rises at the following edge.
module uart_tx
    import nonce_reporter_pkg::*;
#(
    parameter int CLK_DIV = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done,
    output logic       ready
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic        active;
    logic [15:0] bit_cnt;
    logic [3:0]  bit_idx;
    logic [8:0]  frame;     // remaining data bits plus stop bit, LSB next out
    logic        bit_end;

    assign bit_end = active && (bit_cnt == DIV_LAST);
    assign done    = bit_end && (bit_idx == LAST_BIT_IDX);
    assign ready   = !active;

    // Bit timing and shifting; reset returns the line to idle high at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active  <= 1'b0;
            bit_cnt <= 16'd0;
            bit_idx <= 4'd0;
            frame   <= '1;
            tx      <= 1'b1;
        end else if (!active) begin
            if (start) begin
                active  <= 1'b1;
                bit_cnt <= 16'd0;
                bit_idx <= 4'd0;
                frame   <= {1'b1, data};
                tx      <= 1'b0;
            end
        end else if (bit_end) begin
            bit_cnt <= 16'd0;
            if (bit_idx == LAST_BIT_IDX) begin
                active  <= 1'b0;
                bit_idx <= 4'd0;
                tx      <= 1'b1;
            end else begin
                bit_idx <= bit_idx + 4'd1;
                tx      <= frame[0];
                frame   <= {1'b1, frame[8:1]};
            end
        end else begin
            bit_cnt <= bit_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/nonce_reporter.sv
// Buffers winning nonces from the miner in a small FIFO and reports each one
// over a UART as four bytes, most significant byte first.
module nonce_reporter
    import nonce_reporter_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        nonce_found,
    input  logic [31:0] nonce_in,
    input  logic        flush,
    input  logic        clear_overflow,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [1:0]  dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // FIFO storage; pointers carry one extra bit to tell full from empty.
    logic [31:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        drop;

    // Controller
    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_idx;
    logic [31:0] shreg;
    logic        uart_start;
    logic        uart_done;
    logic        uart_ready;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                        (wr_ptr[AW] != rd_ptr[AW]);

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push = nonce_found && !flush && (!fifo_full || pop);
    assign drop = nonce_found && !flush && fifo_full && !pop;

    assign busy      = !fifo_empty || (state != ST_IDLE);
    assign dbg_state = state;

    // FIFO data write; contents need no reset since the pointers gate them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= nonce_in;
        end
    end

    // FIFO pointers; flush discards everything buffered, including a push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Sticky overflow; a fresh drop outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

    // Controller state register, nonce shift register and byte index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            byte_idx <= 2'd0;
            shreg    <= 32'd0;
        end else begin
            state <= state_next;
            if (pop) begin
                shreg    <= mem[rd_ptr[AW-1:0]];
                byte_idx <= 2'd0;
            end else if (state == ST_SEND && uart_done &&
                         byte_idx != LAST_BYTE_IDX) begin
                byte_idx <= byte_idx + 2'd1;
                shreg    <= {shreg[23:0], 8'h00};
            end
        end
    end

    // Next-state logic: pop a nonce, then start and await each of its bytes.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        uart_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty && !flush) begin
                    pop        = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (uart_ready) begin
                    uart_start = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                if (uart_done) begin
                    state_next = (byte_idx == LAST_BYTE_IDX) ? ST_WAIT : ST_LOAD;
                end
            end
            ST_WAIT: begin
                if (!fifo_empty && !flush) begin
                    pop        = 1'b1;
                    state_next = ST_LOAD;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    uart_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_uart_tx (
        .clk   (clk),
        .reset (reset),
        .start (uart_start),
        .data  (shreg[31:24]),
        .tx    (tx),
        .done  (uart_done),
        .ready (uart_ready)
    );

endmodule

// File: tb/tb_nonce_reporter.sv
// Bench for nonce_reporter: directed nonces, a UART receiver monitor that
// pops expected bytes from a scoreboard queue, plus timing and flag checks.
module tb_nonce_reporter;

    localparam int DIV   = 4;
    localparam int HALF  = DIV / 2;
    localparam int DEPTH = 8;

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nonce_found = 1'b0;
    logic [31:0] nonce_in = 32'd0;
    logic        flush = 1'b0;
    logic        clear_overflow = 1'b0;
    logic        tx;
    logic        busy;
    logic        overflow;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    logic [7:0] exp_q[$];
    int         start_cyc[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       mon_abort = 1'b0;

    nonce_reporter #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (rst),
        .nonce_found    (nonce_found),
        .nonce_in       (nonce_in),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .tx             (tx),
        .busy           (busy),
        .overflow       (overflow),
        .dbg_state      (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_vec++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Driver tasks
    task automatic push_nonce(input logic [31:0] n);
        exp_q.push_back(n[31:24]);
        exp_q.push_back(n[23:16]);
        exp_q.push_back(n[15:8]);
        exp_q.push_back(n[7:0]);
    endtask

    task automatic strobe(input logic [31:0] n);
        @(negedge clk);
        nonce_found = 1'b1;
        nonce_in    = n;
        @(negedge clk);
        nonce_found = 1'b0;
    endtask

    task automatic wait_drain(output int idle_cyc);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 5000) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d bytes pending busy=%0b required 0 pending, busy=0", exp_q.size(), busy);
        end
        idle_cyc = cyc;
    endtask

    task automatic wait_starts(input int n);
        int t;
        t = 0;
        while (start_cyc.size() < n && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            n_vec++;
            n_err++;
            $display("FAIL start_timeout: got %0d frames required %0d", start_cyc.size(), n);
        end
    endtask

    // Monitor helper: waits n falling edges, giving up early on reset.
    task automatic wait_neg(input int n);
        for (int j = 0; j < n; j++) begin
            if (!mon_abort) begin
                @(negedge clk);
                if (rst) mon_abort = 1'b1;
            end
        end
    endtask

    // UART monitor: samples each bit mid-period and checks against exp_q.
    initial begin : monitor
        logic [7:0] b;
        logic       sb;
        logic       stp;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                start_cyc.push_back(cyc);
                mon_abort = 1'b0;
                wait_neg(HALF);
                sb = tx;
                for (int i = 0; i < 8; i++) begin
                    wait_neg(DIV);
                    b[i] = tx;
                end
                wait_neg(DIV);
                stp = tx;
                if (!mon_abort) begin
                    check("start_bit", {31'd0, sb}, 32'd0);
                    check("stop_bit", {31'd0, stp}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h required no byte", b);
                    end else begin
                        check("tx_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
                    end
                end
            end
        end
    end

    // Watchdog
    initial begin
        #400000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: got timeout required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Directed tests
    initial begin
        int strobe_cyc;
        int idle_cyc;
        int base;
        int lows;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        // Single nonce, strobe on the first edge after reset release
        start_cyc.delete();
        push_nonce(32'h12345678);
        rst         = 1'b0;
        nonce_found = 1'b1;
        nonce_in    = 32'h12345678;
        strobe_cyc  = cyc;
        @(negedge clk);
        nonce_found = 1'b0;
        repeat (8) @(negedge clk);
        check("busy_mid", {31'd0, busy}, 32'd1);
        check("state_mid", {30'd0, dbg_state}, 32'd2);
        wait_drain(idle_cyc);
        check("frames_1", start_cyc.size(), 32'd4);
        if (start_cyc.size() == 4) begin
            check_range("latency", start_cyc[0] - strobe_cyc, 1, 4);
            for (int i = 1; i < 4; i++) begin
                check_range("byte_spacing", start_cyc[i] - start_cyc[i-1], 40, 42);
            end
            check_range("nonce_span", start_cyc[3] + 40 - start_cyc[0], 160, 166);
            check_range("busy_fall", idle_cyc - start_cyc[3], 40, 43);
        end

        // Ten back-to-back strobes: nine sent, the tenth dropped
        start_cyc.delete();
        for (int i = 1; i <= 9; i++) push_nonce(32'(i));
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 10) check("ovf_before_drop", {31'd0, overflow}, 32'd0);
            nonce_found = 1'b1;
            nonce_in    = 32'(i);
        end
        @(negedge clk);
        nonce_found = 1'b0;
        check("ovf_after_drop", {31'd0, overflow}, 32'd1);
        wait_drain(idle_cyc);
        check("frames_9", start_cyc.size(), 32'd36);
        for (int i = 1; i < start_cyc.size(); i++) begin
            check_range("gap_9", start_cyc[i] - start_cyc[i-1], 40, 42);
        end
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Clear pulse, then clear coincident with a drop
        @(negedge clk);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 1; i <= 9; i++) push_nonce(32'h100 + 32'(i));
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            nonce_found    = 1'b1;
            nonce_in       = 32'h100 + 32'(i);
            clear_overflow = (i == 10);
        end
        @(negedge clk);
        nonce_found    = 1'b0;
        clear_overflow = 1'b0;
        check("ovf_drop_wins", {31'd0, overflow}, 32'd1);
        wait_drain(idle_cyc);

        // Reset in the middle of the first byte
        base = start_cyc.size();
        strobe(32'h55AA55AA);
        wait_starts(base + 1);
        repeat (6) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_tx", {31'd0, tx}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        check("arst_state", {30'd0, dbg_state}, 32'd0);
        repeat (3) @(negedge clk);
        rst  = 1'b0;
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_resume", lows, 32'd0);
        push_nonce(32'hDEADBEEF);
        strobe(32'hDEADBEEF);
        wait_drain(idle_cyc);

        // Flush during byte 2 of the first of three buffered nonces
        push_nonce(32'hA1A2A3A4);
        base = start_cyc.size();
        @(negedge clk);
        nonce_found = 1'b1;
        nonce_in    = 32'hA1A2A3A4;
        @(negedge clk);
        nonce_in    = 32'hB1B2B3B4;
        @(negedge clk);
        nonce_in    = 32'hC1C2C3C4;
        @(negedge clk);
        nonce_found = 1'b0;
        wait_starts(base + 2);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        wait_drain(idle_cyc);
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (100) @(negedge clk);
        check("flush_frames", start_cyc.size() - base, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
